// File: rtl/fsm_fc_bp.sv
// Fully-connected-stage controller: after a conv-forward-done pulse it runs the
// FC forward, loss and FC backward phases, then pulses BP_FC_complete for one cycle.
module fsm_fc_bp #(
    parameter int FWD_CYCLES  = 10,
    parameter int LOSS_CYCLES = 2,
    parameter int BWD_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic       clk,
    input  logic       fsm_rst,
    input  logic       FP_C_complete,
    input  logic       stride,
    output logic       fc_fwd_en,
    output logic       loss_en,
    output logic       fc_bwd_en,
    output logic [1:0] fc_sel,
    output logic       BP_FC_complete,
    output logic       busy,
    output logic       overrun,
    output logic [2:0] curr_state
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FC_FWD = 3'd1,
        LOSS   = 3'd2,
        FC_BWD = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] FWD_LAST  = CNT_W'(FWD_CYCLES - 1);
    localparam logic [CNT_W-1:0] LOSS_LAST = CNT_W'(LOSS_CYCLES - 1);
    localparam logic [CNT_W-1:0] BWD_LAST  = CNT_W'(BWD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic             pending;
    logic             in_phase;

    assign in_phase   = (state == FC_FWD) || (state == LOSS) || (state == FC_BWD);
    assign curr_state = state;

    always_ff @(posedge clk) begin
        if (fsm_rst) begin
            state   <= IDLE;
            count   <= '0;
            pending <= 1'b0;
            overrun <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    count <= '0;
                    if (FP_C_complete) state <= FC_FWD;
                end
                FC_FWD: begin
                    if (count == FWD_LAST) begin
                        state <= LOSS;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                LOSS: begin
                    if (count == LOSS_LAST) begin
                        state <= FC_BWD;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                FC_BWD: begin
                    if (count == BWD_LAST) begin
                        state <= DONE;
                        count <= '0;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    // A request seen during the run (or arriving now) restarts back-to-back.
                    count   <= '0;
                    pending <= 1'b0;
                    state   <= (pending || FP_C_complete) ? FC_FWD : IDLE;
                end
                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase

            // Only one request can be queued; a second one while queued is lost.
            if (FP_C_complete && in_phase) begin
                pending <= 1'b1;
            end
            if (FP_C_complete && pending && (state != DONE)) begin
                overrun <= 1'b1;
            end
        end
    end

    always_comb begin
        fc_fwd_en      = 1'b0;
        loss_en        = 1'b0;
        fc_bwd_en      = 1'b0;
        fc_sel         = 2'b00;
        BP_FC_complete = 1'b0;
        busy           = (state != IDLE);
        case (state)
            FC_FWD: begin
                fc_fwd_en = 1'b1;
                fc_sel    = stride ? 2'b01 : 2'b00;
            end
            LOSS: begin
                loss_en = 1'b1;
                fc_sel  = stride ? 2'b10 : 2'b00;
            end
            FC_BWD: begin
                fc_bwd_en = 1'b1;
                fc_sel    = stride ? 2'b11 : 2'b00;
            end
            DONE:    BP_FC_complete = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_fsm_fc_bp.sv
// Bench for fsm_fc_bp: directed table, hand-written corner sequences and random
// stimulus checked every cycle against a run-offset reference model.
module tb_fsm_fc_bp;

    localparam int F = 10;
    localparam int L = 2;
    localparam int B = 10;
    localparam int T = F + L + B;

    // Output bundle layout: {state[2:0], fwd, loss, bwd, sel[1:0], bp, busy, ovr}
    localparam logic [10:0] V_IDLE = 11'b000_000_00_000;
    localparam logic [10:0] V_FWD  = 11'b001_100_01_010;
    localparam logic [10:0] V_LOSS = 11'b010_010_10_010;
    localparam logic [10:0] V_BWD  = 11'b011_001_11_010;
    localparam logic [10:0] V_DONE = 11'b100_000_00_110;
    localparam logic [10:0] SEL_M  = 11'b000_000_11_000;

    logic       clk = 1'b0;
    logic       fsm_rst = 1'b1;
    logic       FP_C_complete = 1'b0;
    logic       stride = 1'b1;
    logic       fc_fwd_en, loss_en, fc_bwd_en, BP_FC_complete, busy, overrun;
    logic [1:0] fc_sel;
    logic [2:0] curr_state;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: a run is tracked by its cycle offset from the start edge.
    bit m_active = 1'b0;
    int m_k = 0;
    bit m_pend = 1'b0;
    bit m_ovr = 1'b0;

    typedef struct {
        logic        rst;
        logic        fp;
        int          n;
        logic [10:0] exp;
    } vec_t;
    vec_t tbl[$];

    always #5 clk = ~clk;

    fsm_fc_bp #(.FWD_CYCLES(F), .LOSS_CYCLES(L), .BWD_CYCLES(B), .CNT_W(4)) dut (
        .clk(clk), .fsm_rst(fsm_rst), .FP_C_complete(FP_C_complete), .stride(stride),
        .fc_fwd_en(fc_fwd_en), .loss_en(loss_en), .fc_bwd_en(fc_bwd_en), .fc_sel(fc_sel),
        .BP_FC_complete(BP_FC_complete), .busy(busy), .overrun(overrun),
        .curr_state(curr_state)
    );

    function automatic logic [10:0] dut_vec();
        return {curr_state, fc_fwd_en, loss_en, fc_bwd_en, fc_sel, BP_FC_complete, busy, overrun};
    endfunction

    function automatic logic [10:0] model_vec(input logic st);
        logic [10:0] v;
        if (!m_active)       v = V_IDLE;
        else if (m_k < F)     v = V_FWD;
        else if (m_k < F + L) v = V_LOSS;
        else if (m_k < T)     v = V_BWD;
        else                  v = V_DONE;
        if (!st) v = v & ~SEL_M;
        v[0] = m_ovr;
        return v;
    endfunction

    task automatic model_step(input logic fp, input logic rst);
        if (rst) begin
            m_active = 1'b0; m_k = 0; m_pend = 1'b0; m_ovr = 1'b0;
        end else if (!m_active) begin
            if (fp) begin m_active = 1'b1; m_k = 0; end
        end else if (m_k == T) begin
            if (m_pend || fp) begin m_k = 0; m_pend = 1'b0; end
            else m_active = 1'b0;
        end else begin
            if (fp) begin
                if (m_pend) m_ovr = 1'b1;
                m_pend = 1'b1;
            end
            m_k = m_k + 1;
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cycle(input logic fp, input logic rst);
        FP_C_complete = fp;
        fsm_rst = rst;
        @(posedge clk);
        model_step(fp, rst);
        #1;
        chk("model", dut_vec(), model_vec(stride));
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0);
    endtask

    initial begin
        tbl.push_back('{1'b1, 1'b0, 1,  V_IDLE});
        tbl.push_back('{1'b1, 1'b1, 1,  V_IDLE});
        tbl.push_back('{1'b0, 1'b0, 2,  V_IDLE});
        tbl.push_back('{1'b0, 1'b1, 1,  V_FWD});
        tbl.push_back('{1'b0, 1'b0, 9,  V_FWD});
        tbl.push_back('{1'b0, 1'b0, 2,  V_LOSS});
        tbl.push_back('{1'b0, 1'b0, 10, V_BWD});
        tbl.push_back('{1'b0, 1'b0, 1,  V_DONE});
        tbl.push_back('{1'b0, 1'b0, 2,  V_IDLE});

        // Directed table, once with stride=1 and once with stride=0.
        for (int s = 1; s >= 0; s--) begin
            stride = s[0];
            foreach (tbl[e]) begin
                for (int r = 0; r < tbl[e].n; r++) begin
                    cycle(tbl[e].fp, tbl[e].rst);
                    chk($sformatf("table s%0d e%0d", s, e), dut_vec(),
                        s[0] ? tbl[e].exp : (tbl[e].exp & ~SEL_M));
                end
            end
        end
        stride = 1'b1;

        // Request during FC_BWD: back-to-back restart, no overrun.
        cycle(1'b1, 1'b0);
        idle_n(F + L + 3);
        cycle(1'b1, 1'b0);
        idle_n(6);
        chk("pend done pulse", BP_FC_complete, 1);
        cycle(1'b0, 1'b0);
        chk("pend back-to-back state", curr_state, 1);
        chk("pend fwd_en", fc_fwd_en, 1);
        chk("pend no overrun", overrun, 0);
        idle_n(T);
        chk("pend second done", BP_FC_complete, 1);
        cycle(1'b0, 1'b0);
        chk("pend idle after", curr_state, 0);

        // Third request while pending: sticky overrun until reset.
        cycle(1'b1, 1'b0);
        idle_n(3);
        cycle(1'b1, 1'b0);
        idle_n(6);
        chk("ovr in loss", loss_en, 1);
        chk("ovr before", overrun, 0);
        cycle(1'b1, 1'b0);
        chk("ovr set", overrun, 1);
        idle_n(38);
        chk("ovr sticky", overrun, 1);
        chk("ovr idle", curr_state, 0);
        cycle(1'b0, 1'b1);
        chk("ovr cleared by rst", overrun, 0);

        // Reset at count 5 of FC_FWD.
        cycle(1'b1, 1'b0);
        idle_n(5);
        chk("rst mid state", curr_state, 1);
        cycle(1'b0, 1'b1);
        chk("rst mid outputs", dut_vec(), 0);
        for (int i = 0; i < 30; i++) begin
            cycle(1'b0, 1'b0);
            chk("rst no bp", BP_FC_complete, 0);
        end
        cycle(1'b1, 1'b0);
        idle_n(T - 1);
        chk("rst rerun bwd", fc_bwd_en, 1);
        cycle(1'b0, 1'b0);
        chk("rst rerun done", BP_FC_complete, 1);
        cycle(1'b0, 1'b0);
        chk("rst rerun idle", curr_state, 0);

        // Simultaneous request and reset.
        cycle(1'b1, 1'b1);
        chk("fp+rst state", curr_state, 0);
        chk("fp+rst busy", busy, 0);

        // Random stimulus against the model.
        for (int i = 0; i < 4000; i++) begin
            if (i % 500 == 0) stride = 1'($urandom_range(0, 1));
            cycle(($urandom_range(0, 14) == 0), ($urandom_range(0, 299) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
